// File: rtl/sin_gen_pkg.sv
// Shared constants and types for the sin_gen block.
// Holds the sine breakpoint table, FSM state encoding, default precision and saturation value.
// No logic; no latency or backpressure of its own.
package sin_gen_pkg;

    // Default quotient fraction bits per 1/16 segment.
    localparam int FRAC_W_DEF = 15;

    // B[k] = angle (Q2.6 radians) at which sin reaches k/16.
    localparam logic [7:0] B_TAB [0:16] = '{
        8'd0,  8'd4,  8'd8,  8'd12, 8'd16, 8'd20, 8'd25, 8'd29, 8'd34,
        8'd38, 8'd43, 8'd49, 8'd54, 8'd61, 8'd68, 8'd78, 8'd101
    };

    // Angles at or beyond pi/2 (Q2.6 101) clamp to 1.0.
    localparam logic [7:0] ANGLE_SAT = 8'd101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DIV    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Output weight of 1.0 for a given fraction width.
    function automatic logic [63:0] sat_val(input int frac_w);
        return 64'd1 << (frac_w + 4);
    endfunction

endpackage

// File: rtl/sin_gen_div.sv
// Iterative restoring divider: quot = (dividend << NBITS) / divisor, one quotient bit per cycle.
// Latency: start pulse loads operands, done_o high during the last of NBITS iterations.
// No backpressure: start is only issued while idle; quot_o is valid only while done_o is high.
// Ports: CLK_I/RST_N_I, start_i + dividend_i/divisor_i (dividend < divisor), done_o, quot_o.
// SIN_GEN_ROUND_EN: one extra bit is developed and the quotient rounds to nearest, ties up.
module sin_gen_div
    import sin_gen_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              CLK_I,
    input  logic              RST_N_I,
    input  logic              start_i,
    input  logic [7:0]        dividend_i,
    input  logic [7:0]        divisor_i,
    output logic              done_o,
    output logic [FRAC_W:0]   quot_o
);

`ifdef SIN_GEN_ROUND_EN
    localparam int NBITS = FRAC_W + 1;
`else
    localparam int NBITS = FRAC_W;
`endif
    localparam int CW = $clog2(NBITS + 1);

    logic [7:0]       rem_q;
    logic [7:0]       dsr_q;
    logic [NBITS-1:0] quo_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [8:0]       rem_sh;
    logic             fits;
    logic [7:0]       rem_nxt;
    logic [NBITS-1:0] quo_nxt;

    // Remainder stays below the divisor, so the shifted value fits 9 bits and
    // the restored/subtracted remainder always fits back into 8.
    always_comb begin
        rem_sh  = {rem_q, 1'b0};
        fits    = (rem_sh >= {1'b0, dsr_q});
        rem_nxt = fits ? 8'(rem_sh - {1'b0, dsr_q}) : rem_sh[7:0];
        quo_nxt = {quo_q[NBITS-2:0], fits};
    end

    assign done_o = busy_q && (cnt_q == CW'(NBITS - 1));

    // The final bit is folded in combinationally so the result is usable in
    // the same cycle as done_o.
`ifdef SIN_GEN_ROUND_EN
    logic [FRAC_W+1:0] quo_rnd;
    assign quo_rnd = {1'b0, quo_nxt} + {{(FRAC_W+1){1'b0}}, 1'b1};
    assign quot_o  = quo_rnd[FRAC_W+1:1];
`else
    assign quot_o  = {1'b0, quo_nxt};
`endif

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= dividend_i;
            dsr_q  <= divisor_i;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sin_gen.sv
// Sine of a Q2.6 angle by inverse breakpoint lookup plus linear interpolation via a serial divider.
// Latency: k+1+NBITS cycles after accept (NBITS = FRAC_W, +1 with SIN_GEN_ROUND_EN); saturated angles 1 cycle.
// Backpressure: one request in flight, READY_O only when idle; result held in DONE until READY_I.
// Ports: CLK_I, RST_N_I (async active-low), VALID_I/READY_O/ANGLE_I in, VALID_O/READY_I/DATA_O out.
// DATA_O bits [FRAC_W+4:0] carry the value (1.0 = 2^(FRAC_W+4)); higher bits are zero.
module sin_gen
    import sin_gen_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic        VALID_I,
    output logic        READY_O,
    input  logic [7:0]  ANGLE_I,
    output logic        VALID_O,
    input  logic        READY_I,
    output logic [63:0] DATA_O
);

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      ang_q;
    logic [4:0]      k_q;
    logic [63:0]     data_q;

    logic            accept;
    logic            sat;
    logic            search_step;
    logic            div_start;
    logic            div_done;
    logic [FRAC_W:0] div_quot;
    logic [7:0]      div_dividend;
    logic [7:0]      div_divisor;

    assign accept = VALID_I && READY_O;
    assign sat    = (ANGLE_I >= ANGLE_SAT);

    // Walk up the table while the angle has passed the next breakpoint.
    // A < B[16] here, so k never passes 15.
    assign search_step = (ang_q >= B_TAB[k_q + 5'd1]);

    assign div_dividend = ang_q - B_TAB[k_q];
    assign div_divisor  = B_TAB[k_q + 5'd1] - B_TAB[k_q];

    // State register
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (VALID_I) state_d = sat ? DONE : SEARCH;
            SEARCH:  if (!search_step) state_d = DIV;
            DIV:     if (div_done) state_d = DONE;
            DONE:    if (READY_I) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        READY_O   = (state_q == IDLE);
        VALID_O   = (state_q == DONE);
        div_start = (state_q == SEARCH) && !search_step;
    end

    assign DATA_O = data_q;

    // Datapath: angle, segment index and the held result.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            ang_q  <= '0;
            k_q    <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                ang_q <= ANGLE_I;
                k_q   <= '0;
                if (sat) data_q <= sat_val(FRAC_W);
            end
            if (state_q == SEARCH && search_step) k_q <= k_q + 5'd1;
            if (state_q == DIV && div_done) begin
                data_q <= ({59'd0, k_q} << FRAC_W)
                        + {{(63-FRAC_W){1'b0}}, div_quot};
            end
        end
    end

    sin_gen_div #(
        .FRAC_W (FRAC_W)
    ) u_div (
        .CLK_I      (CLK_I),
        .RST_N_I    (RST_N_I),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

endmodule

// File: doc/sin_gen.md
SIN_GEN -- requirements
Module: sin_gen

Interface
REQ-001 SHALL have parameter FRAC_W, default 15, quotient fraction bits per 1/16 segment; 1.0 output weight = 2^(FRAC_W+4).
REQ-002 SHALL have port CLK_I  in  1  clock, all state on rising edge.
REQ-003 SHALL have port RST_N_I  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port VALID_I  in  1  request valid.
REQ-005 SHALL have port READY_O  out  1  block can accept a request.
REQ-006 SHALL have port ANGLE_I  in  8  unsigned angle, radians, Q2.6 (64 = 1.0 rad, 101 ~ pi/2).
REQ-007 SHALL have port VALID_O  out  1  result valid.
REQ-008 SHALL have port READY_I  in  1  downstream accepts result.
REQ-009 SHALL have port DATA_O  out  64  sine, unsigned; bits [FRAC_W+4:0] value, all higher bits zero.

Function
REQ-010 SHALL compute sin(ANGLE_I) by inverse lookup over breakpoint table B[0..16] = 0,4,8,12,16,20,25,29,34,38,43,49,54,61,68,78,101, where B[k] = angle of sine k/16.
REQ-011 SHALL use FSM states IDLE, SEARCH, DIV, DONE; READY_O = 1 only in IDLE, VALID_O = 1 only in DONE.
REQ-012 SHALL accept on VALID_I && READY_O rising edge, latching ANGLE_I into internal register A.
REQ-013 Accept with A >= 101 SHALL go IDLE -> DONE, result = 2^(FRAC_W+4) (saturation).
REQ-014 Otherwise SHALL go IDLE -> SEARCH with k = 0; each SEARCH cycle: if A >= B[k+1] then k++, else -> DIV; SEARCH lasts k+1 cycles.
REQ-015 DIV SHALL run iterative restoring division q = ((A - B[k]) << FRAC_W) / (B[k+1] - B[k]), one quotient bit per cycle, FRAC_W cycles, then -> DONE.
REQ-016 Result SHALL be (k << FRAC_W) + q; q < 2^FRAC_W always, divisor never zero.
REQ-017 DONE SHALL hold VALID_O and DATA_O stable until READY_I = 1; on handshake -> IDLE next cycle.
REQ-018 VALID_I while busy SHALL be ignored; no queuing.
REQ-019 DATA_O SHALL retain last result outside DONE until overwritten.
REQ-020 Latency accept-to-VALID_O (non-saturated, default) SHALL be k+1+FRAC_W cycles; saturated: 1 cycle.

Reset
REQ-021 RST_N_I low SHALL asynchronously force IDLE, READY_O = 1, VALID_O = 0, DATA_O = 0, A = 0, k = 0, divider state = 0.
REQ-022 Reset mid-SEARCH/DIV/DONE SHALL abort the operation with no result delivered.

Configuration
REQ-023 With SIN_GEN_ROUND_EN defined, DIV SHALL compute one extra quotient bit (FRAC_W+1 cycles) and round q to nearest, ties up.
REQ-024 Without SIN_GEN_ROUND_EN, q SHALL be truncated, DIV = FRAC_W cycles.

Structure
REQ-025 Package sin_gen_pkg SHALL hold table B, FSM state enum, FRAC_W default, saturation constant.
REQ-026 Division SHALL be sub-module sin_gen_div (start/done, restoring, width from FRAC_W).

Verification
REQ-027 ANGLE_I=0 -> DATA_O=0x0, VALID_O after 16 cycles (k=0).
REQ-028 ANGLE_I=16 (exact breakpoint) -> k=4, DATA_O=0x20000.
REQ-029 ANGLE_I=6 -> k=1, DATA_O=0xC000; ANGLE_I=30 -> 0x39999 (truncate) / 0x3999A (SIN_GEN_ROUND_EN).
REQ-030 ANGLE_I=101 and 200 -> DATA_O=0x80000, VALID_O 1 cycle after accept.
REQ-031 READY_I=0 for 5 cycles in DONE, VALID_I pulsed meanwhile -> DATA_O stable, request ignored, READY_O returns 1 cycle after handshake.
REQ-032 RST_N_I low mid-DIV -> immediately IDLE, VALID_O=0, DATA_O=0; next request completes correctly.
